// File: rtl/cmos_gray_stream.sv
// OV7670 RGB565 byte-stream front end: pairs sensor bytes into pixels, converts them
// to 10-bit grayscale and emits a framed DVAL/DATA stream with coordinates and error flags.
module cmos_gray_stream #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iVSYNC,
  input  logic       iHREF,
  input  logic [7:0] iDATA,
  output logic       oDVAL,
  output logic [9:0] oDATA,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oSOF,
  output logic       oREADY,
  output logic       oERR
);

  // Frame counter must hold SKIP_FRAMES+1, the value reached on the rise that sets oREADY.
  localparam int          FW       = $clog2(SKIP_FRAMES + 2);
  localparam logic [FW-1:0] SKIP_CNT = FW'(SKIP_FRAMES);
  localparam logic [9:0]  H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
  localparam logic [9:0]  CNT_MAX  = 10'h3FF;

  logic          vsync_d;
  logic          href_d;
  logic          phase;
  logic [7:0]    byte0;
  logic [9:0]    x_cnt;
  logic [9:0]    y_cnt;
  logic [FW-1:0] frame_cnt;

  logic [15:0]   pix_q;
  logic [9:0]    pix_x;
  logic [9:0]    pix_y;
  logic          pix_v;

  logic [15:0]   sum_q;
  logic [9:0]    sum_x;
  logic [9:0]    sum_y;
  logic          sum_v;

  logic          vsync_rise;
  logic          href_fall;
  logic          byte_en;
  logic          pixel_en;
  logic          in_window;
  logic          err_set;
  logic [7:0]    r8;
  logic [7:0]    g8;
  logic [7:0]    b8;
  logic [15:0]   gray_sum;

  assign vsync_rise = iVSYNC & ~vsync_d;
  assign href_fall  = ~iHREF & href_d;
  // Bytes arriving while VSYNC is high belong to no line and are ignored.
  assign byte_en    = iHREF & ~iVSYNC;
  assign pixel_en   = byte_en & phase;
  assign in_window  = (x_cnt < H_LIM) && (y_cnt < V_LIM);

  // Errors are only reported once the stream is live; settling frames are ignored.
  assign err_set = oREADY & ((href_fall & (phase | ((x_cnt != '0) && (x_cnt != H_LIM))))
                           | (pixel_en & ~in_window));

  // Framing, byte pairing and coordinate counters.
  always_ff @(posedge iCLK) begin
    // NOTE: reset is synchronous -- it is just the highest-priority branch inside the clocked block.
    if (!iRST_N) begin
      vsync_d   <= 1'b0;
      href_d    <= 1'b0;
      phase     <= 1'b0;
      byte0     <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      frame_cnt <= '0;
      oREADY    <= 1'b0;
      oERR      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      vsync_d <= iVSYNC;
      href_d  <= iHREF;

      if (vsync_rise) begin
        phase <= 1'b0;
        x_cnt <= '0;
        y_cnt <= '0;
        if (!oREADY) begin
          frame_cnt <= frame_cnt + 1'b1;
          if (frame_cnt == SKIP_CNT) oREADY <= 1'b1;
        end
      end else if (href_fall) begin
        phase <= 1'b0;
        x_cnt <= '0;
        if ((x_cnt != '0) && (y_cnt != CNT_MAX)) y_cnt <= y_cnt + 1'b1;
      end else if (byte_en) begin
        phase <= ~phase;
        if (!phase)                byte0 <= iDATA;
        else if (x_cnt != CNT_MAX) x_cnt <= x_cnt + 1'b1;
      end

      if (err_set) oERR <= 1'b1;
    end
  end

  // Stage 1: assembled RGB565 pixel with its coordinates.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      pix_q <= '0;
      pix_x <= '0;
      pix_y <= '0;
      pix_v <= 1'b0;
    end else begin
      pix_v <= pixel_en & oREADY & in_window;
      if (pixel_en) begin
        pix_q <= {byte0, iDATA};
        pix_x <= x_cnt;
        pix_y <= y_cnt;
      end
    end
  end

  // Channel expansion by MSB replication, then BT.601-style weights summing to 256.
  assign r8 = {pix_q[15:11], pix_q[15:13]};
  assign g8 = {pix_q[10:5],  pix_q[10:9]};
  assign b8 = {pix_q[4:0],   pix_q[4:2]};
  assign gray_sum = 16'(r8) * 16'd77 + 16'(g8) * 16'd150 + 16'(b8) * 16'd29;

  // Stage 2: weighted sum.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sum_q <= '0;
      sum_x <= '0;
      sum_y <= '0;
      sum_v <= 1'b0;
    end else begin
      sum_v <= pix_v;
      sum_q <= gray_sum;
      sum_x <= pix_x;
      sum_y <= pix_y;
    end
  end

  // Stage 3: output register; data and coordinates hold between valid pixels.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oDVAL <= 1'b0;
      oDATA <= '0;
      oX    <= '0;
      oY    <= '0;
      oSOF  <= 1'b0;
    end else begin
      oDVAL <= sum_v;
      oSOF  <= sum_v && (sum_x == '0) && (sum_y == '0);
      if (sum_v) begin
        oDATA <= sum_q[15:6];
        oX    <= sum_x;
        oY    <= sum_y;
      end
    end
  end

endmodule
